alu_pipe: RTL

- Parametrised, pipelined successor to the team's 4-bit combinational ALU.
- Keeps the 16-op select map: sel[3]=0 selects arithmetic, sel[3]=1 selects logic, sel[2:0] picks the op.
- Adds a configurable WIDTH, a two-stage registered pipeline with valid/ready handshakes on both sides, and status flags.
- Sits between the operand register file and the writeback/result bus.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_pipe_if.sv | 22 ++
 rtl/alu_core.sv | 52 +++++
 rtl/alu_pipe.sv | 56 +++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode map, mode bit index and flag bundle shared by the alu_pipe slice.
package alu_pkg;
    localparam int MODE_BIT = 3;
    localparam logic [3:0] OP_INC_A  = 4'b0000;
    localparam logic [3:0] OP_DEC_A  = 4'b0001;
    localparam logic [3:0] OP_SHL1_A = 4'b0010;
    localparam logic [3:0] OP_INC_B  = 4'b0011;
    localparam logic [3:0] OP_DEC_B  = 4'b0100;
    localparam logic [3:0] OP_SHL1_B = 4'b0101;
    localparam logic [3:0] OP_ADD    = 4'b0110;
    localparam logic [3:0] OP_SHL2_A = 4'b0111;
    localparam logic [3:0] OP_NOT_A  = 4'b1000;
    localparam logic [3:0] OP_NOT_B  = 4'b1001;
    localparam logic [3:0] OP_AND    = 4'b1010;
    localparam logic [3:0] OP_OR     = 4'b1011;
    localparam logic [3:0] OP_XOR    = 4'b1100;
    localparam logic [3:0] OP_XNOR   = 4'b1101;
    localparam logic [3:0] OP_NAND   = 4'b1110;
    localparam logic [3:0] OP_NOR    = 4'b1111;
    typedef struct packed {
        logic z;
        logic n;
        logic v;
    } flags_t;
endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand beat in, result beat out, each with a valid/ready handshake.
interface alu_pipe_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH+1:0] y;
    logic             flag_z;
    logic             flag_n;
    logic             flag_v;
    modport master (
        output in_valid, a, b, sel, out_ready,
        input  in_ready, out_valid, y, flag_z, flag_n, flag_v
    );
    modport slave (
        input  in_valid, a, b, sel, out_ready,
        output in_ready, out_valid, y, flag_z, flag_n, flag_v
    );
endinterface

// File: rtl/alu_core.sv
// alu_core: combinational ALU datapath producing y and flags from the stage-1 operands.
// ALU_PIPE_SATURATE_EN clamps overflowing arithmetic results to the WIDTH-bit signed range.
module alu_core import alu_pkg::*; #(parameter int WIDTH = 8) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic [WIDTH+1:0] y,
    output flags_t           f
);
    logic [WIDTH+1:0] ea, eb, one, ar, ys;
    logic [WIDTH-1:0] lr;
    logic             arith, ovf;
    assign ea    = {{2{a[WIDTH-1]}}, a};
    assign eb    = {{2{b[WIDTH-1]}}, b};
    assign one   = {{(WIDTH+1){1'b0}}, 1'b1};
    assign arith = !sel[MODE_BIT];
    always_comb begin
        ar = '0;
        lr = '0;
        case (sel)
            OP_INC_A:  ar = ea + one;
            OP_DEC_A:  ar = ea - one;
            OP_SHL1_A: ar = ea << 1;
            OP_INC_B:  ar = eb + one;
            OP_DEC_B:  ar = eb - one;
            OP_SHL1_B: ar = eb << 1;
            OP_ADD:    ar = ea + eb;
            OP_SHL2_A: ar = ea << 2;
            OP_NOT_A:  lr = ~a;
            OP_NOT_B:  lr = ~b;
            OP_AND:    lr = a & b;
            OP_OR:     lr = a | b;
            OP_XOR:    lr = a ^ b;
            OP_XNOR:   lr = a ~^ b;
            OP_NAND:   lr = ~(a & b);
            OP_NOR:    lr = ~(a | b);
        endcase
    end
    // fits in WIDTH signed bits only when the top three bits agree
    assign ovf = !(&ar[WIDTH+1:WIDTH-1] || ~|ar[WIDTH+1:WIDTH-1]);
`ifdef ALU_PIPE_SATURATE_EN
    logic [WIDTH+1:0] sat;
    assign sat = ar[WIDTH+1] ? {3'b111, {(WIDTH-1){1'b0}}} : {3'b000, {(WIDTH-1){1'b1}}};
    assign ys  = ovf ? sat : ar;
`else
    assign ys  = ar;
`endif
    assign y   = arith ? ys : {2'b00, lr};
    assign f.z = y == '0;
    assign f.n = arith && y[WIDTH+1];
    assign f.v = arith && ovf;
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready pipeline around alu_core (operand stage, result stage).
// Saturating arithmetic is selected in alu_core by ALU_PIPE_SATURATE_EN.
module alu_pipe import alu_pkg::*; #(parameter int WIDTH = 8) (
    input logic       clk,
    input logic       rst,
    alu_pipe_if.slave bus
);
    logic             s1_valid, s2_valid, s1_adv, s2_adv;
    logic [WIDTH-1:0] s1_a, s1_b;
    logic [3:0]       s1_sel;
    logic [WIDTH+1:0] core_y, s2_y;
    flags_t           core_f, s2_f;
    assign s2_adv       = !s2_valid || bus.out_ready;
    assign s1_adv       = !s1_valid || s2_adv;
    assign bus.in_ready = s1_adv;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_sel   <= '0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_a   <= bus.a;
                s1_b   <= bus.b;
                s1_sel <= bus.sel;
            end
        end
    end
    alu_core #(.WIDTH(WIDTH)) u_core (
        .a   (s1_a),
        .b   (s1_b),
        .sel (s1_sel),
        .y   (core_y),
        .f   (core_f)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_y     <= '0;
            s2_f     <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_y <= core_y;
                s2_f <= core_f;
            end
        end
    end
    assign bus.out_valid = s2_valid;
    assign bus.y         = s2_y;
    assign bus.flag_z    = s2_f.z;
    assign bus.flag_n    = s2_f.n;
    assign bus.flag_v    = s2_f.v;
endmodule
